// File: rtl/uart_rx_os.sv
// UART receiver with oversampled majority-vote bit decisions, optional parity
// and 1/2 stop bits. Emits one-cycle valid with parity/framing flags.
module uart_rx_os #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0,
  parameter int P_OVERSAMPLE      = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_user_rx_parity_err,
  output logic                         o_user_rx_frame_err,
  output logic                         o_user_rx_busy
);

  localparam int DIV_RAW = P_SYSTEM_CLK / (P_UART_BUADRATE * P_OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NW      = $clog2(P_OVERSAMPLE);
  localparam int W       = P_UART_DATA_WIDTH;
  localparam int BW      = $clog2(W);

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [NW-1:0] N_LO    = NW'(P_OVERSAMPLE / 2 - 1);
  localparam logic [NW-1:0] N_MID   = NW'(P_OVERSAMPLE / 2);
  localparam logic [NW-1:0] N_DEC   = NW'(P_OVERSAMPLE / 2 + 1);
  localparam logic [NW-1:0] N_END   = NW'(P_OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(W - 1);
  localparam logic          STOP_MAX = 1'(P_UART_STOP_WIDTH - 1);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_PARITY    = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]    state;
  logic          rx_meta, rxs;
  logic [1:0]    settle;
  logic [CW-1:0] cnt;
  logic [NW-1:0] n;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bitcnt;
  logic          stopcnt;
  logic          par_bit, ferr_acc;
  logic          s_lo, s_mid;
  logic          active, tick, at_lo, at_mid, at_dec, at_end, maj;
  logic          par_exp, par_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      settle  <= 2'b00;
    end else begin
      rx_meta <= i_uart_rx;
      rxs     <= rx_meta;
      settle  <= {settle[0], 1'b1};
    end
  end

  assign active = (state == S_START) || (state == S_DATA) ||
                  (state == S_PARITY) || (state == S_STOP);
  assign tick   = active && (cnt == CNT_MAX);
  assign at_lo  = tick && (n == N_LO);
  assign at_mid = tick && (n == N_MID);
  assign at_dec = tick && (n == N_DEC);
  assign at_end = tick && (n == N_END);
  assign maj    = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

  assign par_exp = (P_UART_CHECK == 1) ? ~(^shreg) : (^shreg);
  assign par_err = (P_UART_CHECK != 0) && (par_bit != par_exp);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      n   <= '0;
    end else if (!active) begin
      cnt <= '0;
      n   <= '0;
    end else if (tick) begin
      cnt <= '0;
      n   <= (n == N_END) ? '0 : n + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= S_WAIT_IDLE;
      shreg                <= '0;
      bitcnt               <= '0;
      stopcnt              <= 1'b0;
      par_bit              <= 1'b0;
      ferr_acc             <= 1'b0;
      s_lo                 <= 1'b0;
      s_mid                <= 1'b0;
      o_user_rx_data       <= '0;
      o_user_rx_parity_err <= 1'b0;
      o_user_rx_frame_err  <= 1'b0;
    end else begin
      if (at_lo)  s_lo  <= rxs;
      if (at_mid) s_mid <= rxs;
      case (state)
        // The synchroniser flops reset high, so a high rxs only counts once
        // the pin has actually propagated through both stages.
        S_WAIT_IDLE: if (rxs && settle[1]) state <= S_IDLE;
        S_IDLE: if (!rxs) begin
          state    <= S_START;
          bitcnt   <= '0;
          stopcnt  <= 1'b0;
          ferr_acc <= 1'b0;
        end
        S_START: begin
          if (at_dec && maj) state <= S_IDLE;
          else if (at_end)   state <= S_DATA;
        end
        S_DATA: begin
          if (at_dec) shreg <= {maj, shreg[W-1:1]};
          if (at_end) begin
            if (bitcnt == BIT_MAX) state <= (P_UART_CHECK != 0) ? S_PARITY : S_STOP;
            else                   bitcnt <= bitcnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (at_dec) par_bit <= maj;
          if (at_end) state <= S_STOP;
        end
        S_STOP: begin
          // Finish at the last stop decision so a following start edge is seen.
          if (at_dec) begin
            if (!maj) ferr_acc <= 1'b1;
            if (stopcnt == STOP_MAX) begin
              state                <= S_DONE;
              o_user_rx_data       <= shreg;
              o_user_rx_frame_err  <= ferr_acc | ~maj;
              o_user_rx_parity_err <= par_err;
            end
          end
          if (at_end) stopcnt <= stopcnt + 1'b1;
        end
        S_DONE:  state <= o_user_rx_frame_err ? S_WAIT_IDLE : S_IDLE;
        default: state <= S_WAIT_IDLE;
      endcase
    end
  end

  assign o_user_rx_valid = (state == S_DONE);
  assign o_user_rx_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three instances (fast no-parity, fast even
// parity, default clocking), directed frames, per-instance output monitors.
module tb_uart_rx_os;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    longint     cyc;
  } exp_t;

  localparam int FAST_CLK = 614_400;   // DIV = 4
  localparam int BIT_F    = 64;
  localparam int BIT_D    = 16 * 325;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_p = 1'b1, rx_d = 1'b1;
  logic [7:0] d_a, d_p, d_d;
  logic v_a, v_p, v_d, pe_a, pe_p, pe_d, fe_a, fe_p, fe_d, b_a, b_p, b_d;

  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t qa[$], qp[$], qd[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.P_SYSTEM_CLK(FAST_CLK)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_a), .o_user_rx_data(d_a),
    .o_user_rx_valid(v_a), .o_user_rx_parity_err(pe_a),
    .o_user_rx_frame_err(fe_a), .o_user_rx_busy(b_a));

  uart_rx_os #(.P_SYSTEM_CLK(FAST_CLK), .P_UART_CHECK(2)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_p), .o_user_rx_data(d_p),
    .o_user_rx_valid(v_p), .o_user_rx_parity_err(pe_p),
    .o_user_rx_frame_err(fe_p), .o_user_rx_busy(b_p));

  uart_rx_os dut_d (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_d), .o_user_rx_data(d_d),
    .o_user_rx_valid(v_d), .o_user_rx_parity_err(pe_d),
    .o_user_rx_frame_err(fe_d), .o_user_rx_busy(b_d));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic compare(input string nm, input exp_t e, input logic [7:0] d,
                         input logic pe, input logic fe);
    checks++;
    if (d !== e.data || pe !== e.perr || fe !== e.ferr || (e.cyc >= 0 && cyc != e.cyc)) begin
      errors++;
      $display("FAIL %s got data=%h perr=%b ferr=%b cyc=%0d want data=%h perr=%b ferr=%b cyc=%0d",
               nm, d, pe, fe, cyc, e.data, e.perr, e.ferr, e.cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [7:0] d);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_valid got data=%h want no valid", nm, d);
  endtask

  always @(negedge clk) if (v_a) begin
    if (qa.size() == 0) unexpected("a", d_a);
    else compare("a_frame", qa.pop_front(), d_a, pe_a, fe_a);
  end
  always @(negedge clk) if (v_p) begin
    if (qp.size() == 0) unexpected("p", d_p);
    else compare("p_frame", qp.pop_front(), d_p, pe_p, fe_p);
  end
  always @(negedge clk) if (v_d) begin
    if (qd.size() == 0) unexpected("d", d_d);
    else compare("d_frame", qd.pop_front(), d_d, pe_d, fe_d);
  end

  task automatic set_line(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_p = v;
      default: rx_d = v;
    endcase
  endtask

  task automatic wait_cyc(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Drives one frame; frame bit glitch_b is inverted only around sample 8.
  task automatic send_frame(input int which, input logic [7:0] data, input bit has_par,
                            input logic par, input logic stop, input int bit_cyc,
                            input int glitch_b);
    logic [11:0] bits;
    int nb, dv, ctr;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (has_par) begin bits[nb] = par; nb++; end
    bits[nb] = stop; nb++;
    dv  = bit_cyc / 16;
    ctr = 9 * dv;
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < bit_cyc; j++) begin
        set_line(which, bits[b] ^ (b == glitch_b && j >= ctr - 2 && j <= ctr + 1));
        wait_cyc(1);
      end
    set_line(which, 1'b1);
  endtask

  task automatic push(input int which, input logic [7:0] d, input logic pe,
                      input logic fe, input longint c);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.cyc = c;
    case (which)
      0: qa.push_back(e);
      1: qp.push_back(e);
      default: qd.push_back(e);
    endcase
  endtask

  initial begin
    wait_cyc(3);
    check("rst_valid", v_a, 0);
    check("rst_data", d_a, 0);
    check("rst_flags", {pe_a, fe_a}, 0);
    check("rst_busy", b_a, 1);
    rst = 1'b0;
    wait_cyc(6);
    check("idle_busy", b_a, 0);

    // default clocking: valid exactly 154*325+1 cycles after rxs sees start
    push(2, 8'h55, 0, 0, cyc + 3 + 154 * 325);
    send_frame(2, 8'h55, 0, 0, 1, BIT_D, -1);
    wait_cyc(100);

    push(0, 8'h55, 0, 0, cyc + 3 + 154 * 4);
    send_frame(0, 8'h55, 0, 0, 1, BIT_F, -1);
    wait_cyc(20);

    // framing error: stop low, line low three bit times
    push(0, 8'hC3, 0, 1, -1);
    send_frame(0, 8'hC3, 0, 0, 0, BIT_F, -1);
    set_line(0, 1'b0);
    wait_cyc(2 * BIT_F);
    check("ferr_hold_busy", b_a, 1);
    set_line(0, 1'b1);
    wait_cyc(10);
    check("ferr_recover_busy", b_a, 0);
    push(0, 8'h3C, 0, 0, -1);
    send_frame(0, 8'h3C, 0, 0, 1, BIT_F, -1);
    wait_cyc(20);

    // 4-tick glitch is a false start
    set_line(0, 1'b0);
    wait_cyc(16);
    set_line(0, 1'b1);
    check("glitch_busy_start", b_a, 1);
    wait_cyc(BIT_F - 16 + 4);
    check("glitch_busy_clear", b_a, 0);
    wait_cyc(20);

    push(0, 8'hF0, 0, 0, -1);
    send_frame(0, 8'hF0, 0, 0, 1, BIT_F, 4);
    wait_cyc(20);

    push(0, 8'h12, 0, 0, -1);
    push(0, 8'h34, 0, 0, -1);
    send_frame(0, 8'h12, 0, 0, 1, BIT_F, -1);
    send_frame(0, 8'h34, 0, 0, 1, BIT_F, -1);
    wait_cyc(20);

    // even parity: 0xA5 has four ones, parity bit 0
    push(1, 8'hA5, 1, 0, -1);
    send_frame(1, 8'hA5, 1, 1, 1, BIT_F, -1);
    wait_cyc(20);
    push(1, 8'hA5, 0, 0, -1);
    send_frame(1, 8'hA5, 1, 0, 1, BIT_F, -1);
    wait_cyc(20);
    push(1, 8'h07, 0, 0, -1);
    send_frame(1, 8'h07, 1, 1, 1, BIT_F, -1);
    wait_cyc(20);

    // reset in the middle of data bit 4 (frame bit 5) of 0x81
    set_line(0, 1'b0);
    wait_cyc(BIT_F);
    for (int i = 0; i < 4; i++) begin
      set_line(0, (i == 0) ? 1'b1 : 1'b0);
      wait_cyc(BIT_F);
    end
    set_line(0, 1'b0);
    wait_cyc(BIT_F / 2);
    rst = 1'b1;
    #1;
    check("midrst_data", d_a, 0);
    check("midrst_valid", v_a, 0);
    check("midrst_busy", b_a, 1);
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(4 * BIT_F);
    check("lowrel_busy", b_a, 1);
    set_line(0, 1'b1);
    wait_cyc(10);
    check("highrel_busy", b_a, 0);
    push(0, 8'h81, 0, 0, -1);
    send_frame(0, 8'h81, 0, 0, 1, BIT_F, -1);

    wait_cyc(200);
    check("a_queue_drained", qa.size(), 0);
    check("p_queue_drained", qp.size(), 0);
    check("d_queue_drained", qd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
